psum_accumulator: RTL and testbench
===================================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 The block SHALL have parameter IW, default 16, giving the signed input term width.
REQ-002 The block SHALL have parameter AW, default 32, giving the signed accumulator and result width; AW SHALL be greater than IW.
REQ-003 The block SHALL have parameter CW, default 8, giving the beat-counter width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1, meaning an input term is offered.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts the offered term.
REQ-008 The block SHALL have port in_data, input, IW, the signed two's-complement term.
REQ-009 The block SHALL have port in_last, input, 1, marking the final term of a group.
REQ-010 The block SHALL have port fp_dst, input, 2, the destination-format code for the group.
REQ-011 The block SHALL have port out_valid, output, 1, meaning a result is held.
REQ-012 The block SHALL have port out_ready, input, 1, meaning the downstream converter takes the result.
REQ-013 The block SHALL have port out_data, output, AW, the signed group sum that drives the converter's 32-bit input.
REQ-014 The block SHALL have port out_fp_dst, output, 2, the group's format code that drives the converter's fp_dst.
REQ-015 The block SHALL have port out_sat, output, 1, set when any add in the group saturated.
REQ-016 The block SHALL have port out_trunc, output, 1, set when the group was force-terminated by the counter.
REQ-017 The block SHALL have port out_cnt, output, CW, the number of terms in the group.
REQ-018 The block SHALL have port busy, output, 1, high while a group is in progress.

Function
REQ-019 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1; all other input cycles are ignored.
REQ-020 in_ready SHALL be combinational and equal to NOT(out_valid AND NOT out_ready).
REQ-021 The state machine SHALL have two states, IDLE and ACC.
REQ-022 In IDLE, an accepted non-final beat SHALL cause a transition to ACC.
REQ-023 In ACC, an accepted final beat SHALL cause a transition to IDLE.
REQ-024 busy SHALL be 1 exactly when the state is ACC.
REQ-025 On the first beat of a group (state IDLE), the accumulator SHALL load sign-extended in_data, the count SHALL load 1, the sat flag SHALL load 0, and fp_dst SHALL be captured.
REQ-026 Changes to fp_dst during ACC SHALL be ignored.
REQ-027 On each subsequent beat, acc SHALL become sat(acc + sext(in_data)) and the count SHALL increment by 1.
REQ-028 sat() SHALL clamp positive overflow to 2^(AW-1)-1 (0x7FFFFFFF) and negative overflow to -2^(AW-1) (0x80000000).
REQ-029 Any clamp SHALL set the group's sticky sat flag; once clamped, accumulation SHALL continue from the clamped value.
REQ-030 A beat SHALL be final if in_last=1, or if the count after that beat equals 2^CW-1 and in_last=0; in the second case out_trunc SHALL be 1, otherwise 0.
REQ-031 A single-beat group (in_last=1 in IDLE) SHALL be legal, give out_cnt=1, and leave the state in IDLE.
REQ-032 On an accepted final beat, the result registers SHALL load on the same edge: out_data gets the final sum including that beat, plus out_fp_dst, out_sat, out_trunc and out_cnt, and out_valid is set to 1. Latency is one cycle from the final-beat edge to out_valid.
REQ-033 While out_valid=1 and out_ready=0, every out_* signal SHALL hold stable.
REQ-034 When out_valid=1 and out_ready=1 with no final beat accepted, out_valid SHALL clear on the next edge.
REQ-035 When an output handshake and an accepted final beat occur in the same cycle, the result registers SHALL reload with the new group and out_valid SHALL stay 1, so no bubble is inserted and no result is lost.
REQ-036 While the output is stalled, in_ready=0 SHALL block all beats, including non-final beats; the accumulator, count and state SHALL hold.

Reset
REQ-037 While rst_n=0, the block SHALL immediately force: state=IDLE, acc=0, count=0, out_valid=0, out_data=0, out_fp_dst=0, out_sat=0, out_trunc=0, out_cnt=0, busy=0.
REQ-038 An assertion of rst_n mid-group or with a pending output SHALL discard the partial sum and the held result; no result SHALL be emitted for that group after release.
REQ-039 The first beat accepted after release SHALL start a new group.

Verification
REQ-040 The bench SHALL cover: terms 3, -5, 10 with in_last on the third beat, fp_dst=2'b10, out_ready=1 -> one cycle later out_data=8, out_cnt=3, out_fp_dst=2'b10, out_sat=0, out_trunc=0.
REQ-041 The bench SHALL cover positive saturation: with IW=16 and 0x7FFF fed for 70000 beats, CW raised to 17 so the counter does not force termination, and in_last on the last beat -> out_data=0x7FFFFFFF, out_sat=1.
REQ-042 The bench SHALL cover back-pressure: out_ready=0 with a result held -> in_ready=0 and out_* stable for 5 cycles; then raise out_ready with a single-beat group of 7 offered in the same cycle -> out_valid stays 1 and out_data=7 on the next edge.
REQ-043 The bench SHALL cover truncation: CW=4, 20 beats of 1 with in_last=0 -> first result out_data=15, out_cnt=15, out_trunc=1; with in_last on beat 20 the second result is out_data=5, out_cnt=5, out_trunc=0.
REQ-044 The bench SHALL cover reset: rst_n pulsed low after 2 of 4 beats -> out_valid=0 and busy=0 immediately; the next group of 4 and 6 with in_last -> out_data=10, out_cnt=2.
REQ-045 The bench SHALL cover a format change: fp_dst=2'b11 on beat 1, then 2'b01 on beats 2 and 3 -> out_fp_dst=2'b11.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums signed IW-bit terms into a saturating AW-bit
// group total; one registered result per group over a valid/ready pair.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          term handshake (in_ready is combinational)
//   in_data, in_last, fp_dst   term, end-of-group flag, group format code
//   out_valid/out_ready        result handshake
//   out_data, out_fp_dst       group sum and captured format code
//   out_sat, out_trunc         sticky clamp flag, counter-forced end
//   out_cnt                    terms in the group
//   busy                       group in progress
module psum_accumulator #(
   parameter int IW = 16,
   parameter int AW = 32,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] in_data,
   input  logic          in_last,
   input  logic [1:0]    fp_dst,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_data,
   output logic [1:0]    out_fp_dst,
   output logic          out_sat,
   output logic          out_trunc,
   output logic [CW-1:0] out_cnt,
   output logic          busy
);

   typedef enum logic {IDLE, ACC} state_t;

   localparam logic [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
   localparam logic [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};
   localparam logic [CW-1:0] CMAX = '1;

   state_t        state_q;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sat_q, sat_d;
   logic [1:0]    fpd_q, fpd_d;

   logic          ov_q;
   logic [AW-1:0] od_q;
   logic [1:0]    ofp_q;
   logic          os_q, ot_q;
   logic [CW-1:0] oc_q;

   logic          accept, first, ovf, trunc, fin;
   logic [AW:0]   sum;

   assign in_ready = ~(ov_q & ~out_ready);
   assign accept   = in_valid & in_ready;
   assign first    = (state_q == IDLE);

   // One guard bit: overflow shows as disagreement of the top two bits.
   assign sum = {acc_q[AW-1], acc_q}
              + {{(AW+1-IW){in_data[IW-1]}}, in_data};
   assign ovf = sum[AW] ^ sum[AW-1];

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      sat_d = sat_q;
      fpd_d = fpd_q;
      if (first) begin
         acc_d = {{(AW-IW){in_data[IW-1]}}, in_data};
         cnt_d = CW'(1);
         sat_d = 1'b0;
         fpd_d = fp_dst;
      end else begin
         acc_d = ovf ? (sum[AW] ? MINV : MAXV) : sum[AW-1:0];
         cnt_d = cnt_q + CW'(1);
         sat_d = sat_q | ovf;
      end
   end

   // Counter-forced end only when the producer did not end it itself.
   assign trunc = ~in_last & (cnt_d == CMAX);
   assign fin   = in_last | trunc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         fpd_q   <= 2'b00;
         ov_q    <= 1'b0;
         od_q    <= '0;
         ofp_q   <= 2'b00;
         os_q    <= 1'b0;
         ot_q    <= 1'b0;
         oc_q    <= '0;
      end else begin
         if (accept) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            fpd_q   <= fpd_d;
            state_q <= fin ? IDLE : ACC;
         end
         // A final beat reloads the result even while the old one is
         // being taken, so back-to-back groups need no bubble.
         if (accept && fin) begin
            ov_q  <= 1'b1;
            od_q  <= acc_d;
            ofp_q <= fpd_d;
            os_q  <= sat_d;
            ot_q  <= trunc;
            oc_q  <= cnt_d;
         end else if (out_ready) begin
            ov_q  <= 1'b0;
         end
      end
   end

   assign out_valid  = ov_q;
   assign out_data   = od_q;
   assign out_fp_dst = ofp_q;
   assign out_sat    = os_q;
   assign out_trunc  = ot_q;
   assign out_cnt    = oc_q;
   assign busy       = (state_q == ACC);

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: scoreboard bench for psum_accumulator.
// Three instances: default, wide counter (CW=17), narrow (AW=17, CW=4).
module tb_psum_accumulator;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   typedef struct {
      longint     data;
      int         cnt;
      logic [1:0] fpd;
      bit         sat;
      bit         trunc;
   } exp_t;

   exp_t q0[$], q1[$], q2[$];
   int n_vec = 0;
   int n_bad = 0;

   // default instance
   logic        a_iv = 0, a_ir, a_il = 0, a_ov, a_or = 1, a_os, a_ot, a_busy;
   logic [15:0] a_id = 0;
   logic [1:0]  a_fp = 0, a_ofp;
   logic [31:0] a_od;
   logic [7:0]  a_oc;
   // wide-counter instance
   logic        s_iv = 0, s_ir, s_il = 0, s_ov, s_or = 1, s_os, s_ot, s_busy;
   logic [15:0] s_id = 0;
   logic [1:0]  s_fp = 0, s_ofp;
   logic [31:0] s_od;
   logic [16:0] s_oc;
   // narrow instance
   logic        t_iv = 0, t_ir, t_il = 0, t_ov, t_or = 1, t_os, t_ot, t_busy;
   logic [15:0] t_id = 0;
   logic [1:0]  t_fp = 0, t_ofp;
   logic [16:0] t_od;
   logic [3:0]  t_oc;

   psum_accumulator u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
      .in_data(a_id), .in_last(a_il), .fp_dst(a_fp), .out_valid(a_ov),
      .out_ready(a_or), .out_data(a_od), .out_fp_dst(a_ofp),
      .out_sat(a_os), .out_trunc(a_ot), .out_cnt(a_oc), .busy(a_busy));

   psum_accumulator #(.IW(16), .AW(32), .CW(17)) u_s (
      .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir),
      .in_data(s_id), .in_last(s_il), .fp_dst(s_fp), .out_valid(s_ov),
      .out_ready(s_or), .out_data(s_od), .out_fp_dst(s_ofp),
      .out_sat(s_os), .out_trunc(s_ot), .out_cnt(s_oc), .busy(s_busy));

   psum_accumulator #(.IW(16), .AW(17), .CW(4)) u_t (
      .clk(clk), .rst_n(rst_n), .in_valid(t_iv), .in_ready(t_ir),
      .in_data(t_id), .in_last(t_il), .fp_dst(t_fp), .out_valid(t_ov),
      .out_ready(t_or), .out_data(t_od), .out_fp_dst(t_ofp),
      .out_sat(t_os), .out_trunc(t_ot), .out_cnt(t_oc), .busy(t_busy));

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference model state, one slot per instance
   longint     m_acc[3];
   int         m_cnt[3];
   bit         m_sat[3];
   logic [1:0] m_fpd[3];
   bit         m_busy[3];

   function automatic int aw_of(input int d);
      return (d == 2) ? 17 : 32;
   endfunction

   function automatic int cw_of(input int d);
      return (d == 0) ? 8 : ((d == 1) ? 17 : 4);
   endfunction

   task automatic mbeat(input int d, input longint v, input bit last,
                        input logic [1:0] f);
      longint mx, mn, s;
      bit tr;
      exp_t e;
      mx = (64'sd1 <<< (aw_of(d) - 1)) - 1;
      mn = -mx - 1;
      if (!m_busy[d]) begin
         m_acc[d] = v; m_cnt[d] = 1; m_sat[d] = 0; m_fpd[d] = f;
      end else begin
         s = m_acc[d] + v;
         if (s > mx) begin s = mx; m_sat[d] = 1; end
         else if (s < mn) begin s = mn; m_sat[d] = 1; end
         m_acc[d] = s;
         m_cnt[d]++;
      end
      tr = !last && (m_cnt[d] == (1 << cw_of(d)) - 1);
      if (last || tr) begin
         e.data = m_acc[d]; e.cnt = m_cnt[d]; e.fpd = m_fpd[d];
         e.sat = m_sat[d]; e.trunc = tr;
         case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
         endcase
         m_busy[d] = 0;
      end else begin
         m_busy[d] = 1;
      end
   endtask

   task automatic drive(input int d, input bit v, input longint x,
                        input bit l, input logic [1:0] f);
      case (d)
         0: begin a_iv = v; a_id = x[15:0]; a_il = l; a_fp = f; end
         1: begin s_iv = v; s_id = x[15:0]; s_il = l; s_fp = f; end
         default: begin t_iv = v; t_id = x[15:0]; t_il = l; t_fp = f; end
      endcase
   endtask

   function automatic logic rdy(input int d);
      return (d == 0) ? a_ir : ((d == 1) ? s_ir : t_ir);
   endfunction

   // Offer one beat, wait (bounded) for acceptance, then update the model.
   task automatic beat(input int d, input longint x, input bit l,
                       input logic [1:0] f);
      bit ok;
      ok = 0;
      drive(d, 1, x, l, f);
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = rdy(d);
         @(posedge clk);
      end
      if (!ok) chk("beat_accept_timeout", 0, 1);
      else mbeat(d, x, l, f);
      #1;
      drive(d, 0, 0, 0, 2'b00);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pop_chk(input int d, input logic signed [63:0] dat,
                          input logic [63:0] cnt, input logic [1:0] f,
                          input logic s, input logic tr);
      exp_t e;
      int sz;
      sz = (d == 0) ? q0.size() : ((d == 1) ? q1.size() : q2.size());
      if (sz == 0) begin
         chk($sformatf("d%0d_unexpected_result", d), 1, 0);
      end else begin
         case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         chk($sformatf("d%0d_data", d), dat, e.data);
         chk($sformatf("d%0d_cnt", d), cnt, e.cnt);
         chk($sformatf("d%0d_fpd", d), f, e.fpd);
         chk($sformatf("d%0d_sat", d), s, e.sat);
         chk($sformatf("d%0d_trunc", d), tr, e.trunc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (a_ov && a_or) pop_chk(0, $signed(a_od), a_oc, a_ofp, a_os, a_ot);
         if (s_ov && s_or) pop_chk(1, $signed(s_od), s_oc, s_ofp, s_os, s_ot);
         if (t_ov && t_or) pop_chk(2, $signed(t_od), t_oc, t_ofp, t_os, t_ot);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic signed [15:0] r;
      int len;
      logic [1:0] f;

      rst_n = 1'b0;
      #1;
      chk("rst_ov", a_ov, 0);
      chk("rst_od", a_od, 0);
      chk("rst_oc", a_oc, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_ir", a_ir, 1);
      chk("rst_flags", {a_ofp, a_os, a_ot}, 0);
      chk("rst_ov_s", s_ov, 0);
      chk("rst_ov_t", t_ov, 0);
      #11 rst_n = 1'b1;
      idle(1);

      // basic group
      beat(0, 3, 0, 2'b10);
      beat(0, -5, 0, 2'b10);
      beat(0, 10, 1, 2'b10);
      idle(2);

      // format code changes mid-group are ignored
      beat(0, 1, 0, 2'b11);
      chk("busy_mid", a_busy, 1);
      beat(0, 2, 0, 2'b01);
      beat(0, 3, 1, 2'b01);
      idle(2);

      // random groups
      for (int g = 0; g < 6; g++) begin
         len = $urandom_range(1, 6);
         f = 2'($urandom_range(0, 3));
         for (int k = 0; k < len; k++) begin
            r = 16'($urandom);
            beat(0, longint'(r), k == len - 1, f);
         end
      end
      idle(2);

      // back-pressure
      a_or = 0;
      beat(0, 100, 1, 2'b01);
      drive(0, 1, 7, 1, 2'b10);
      if (q0.size() == 0) chk("bp_no_expect", 0, 1);
      else begin
         e = q0[0];
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ir", a_ir, 0);
            chk("bp_ov", a_ov, 1);
            chk("bp_od", $signed(a_od), e.data);
            chk("bp_oc", a_oc, e.cnt);
            chk("bp_ofp", a_ofp, e.fpd);
            chk("bp_busy", a_busy, 0);
         end
      end
      @(posedge clk);
      #1 a_or = 1;
      @(negedge clk);
      chk("bp_ir_up", a_ir, 1);
      @(posedge clk);
      mbeat(0, 7, 1, 2'b10);
      #1 drive(0, 0, 0, 0, 2'b00);
      @(negedge clk);
      chk("bp_ov_kept", a_ov, 1);
      chk("bp_od7", $signed(a_od), 7);
      idle(2);

      // reset with a held result: it is discarded
      a_or = 0;
      beat(0, 9, 1, 2'b01);
      #1 rst_n = 1'b0;
      q0.delete();
      m_busy[0] = 0;
      #1;
      chk("rst_held_ov", a_ov, 0);
      #3 rst_n = 1'b1;
      a_or = 1;
      idle(1);

      // reset mid-group
      beat(0, 1, 0, 2'b00);
      beat(0, 2, 0, 2'b00);
      #1 rst_n = 1'b0;
      m_busy[0] = 0;
      #1;
      chk("rst_mid_ov", a_ov, 0);
      chk("rst_mid_busy", a_busy, 0);
      #3 rst_n = 1'b1;
      idle(1);
      beat(0, 4, 0, 2'b00);
      beat(0, 6, 1, 2'b00);
      idle(2);

      // counter-forced termination, then a normal group
      for (int i = 1; i <= 20; i++) beat(2, 1, i == 20, 2'b00);
      idle(2);
      // negative clamp, then positive clamp with continuation
      beat(2, -32768, 0, 2'b01);
      beat(2, -32768, 0, 2'b01);
      beat(2, -32768, 1, 2'b01);
      beat(2, 32767, 0, 2'b10);
      beat(2, 32767, 0, 2'b10);
      beat(2, 32767, 0, 2'b10);
      beat(2, -1, 1, 2'b10);
      idle(2);

      // long positive saturation
      for (int i = 0; i < 70000; i++) beat(1, 32767, i == 69999, 2'b00);
      idle(4);

      chk("q0_left", q0.size(), 0);
      chk("q1_left", q1.size(), 0);
      chk("q2_left", q2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
